// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
//
// Main control unit for the multicycle MIPS datapath. A Moore-style FSM walks
// each instruction through fetch, decode, execute, memory and write-back
// cycles and drives every datapath enable / mux select from the current
// state. Memory accesses (FETCH, MEMRD, MEMWR) stall on memready.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; forces FETCH
//   op[5:0]      in   opcode IR[31:26]; looked at only in DECODE and MEMADR
//   memready     in   memory access completes this cycle
//   pcwrite      out  PC write enable (memready-gated in FETCH)
//   pcwritecond  out  PC write enable qualified by ALU zero (beq)
//   iord         out  memory address from ALUOut instead of PC
//   memread      out  memory read request
//   memwrite     out  memory write request (held through wait cycles)
//   irwrite      out  instruction register load (memready-gated)
//   memtoreg     out  register write data from MDR
//   regdst       out  destination register from rd field
//   regwrite     out  register file write enable
//   alusrca      out  ALU A from register A instead of PC
//   alusrcb[1:0] out  00 B, 01 four, 10 signext imm, 11 signext imm << 2
//   pcsource[1:0]out  00 ALU result, 01 ALUOut, 10 jump target
//   aluop1/0     out  00 add, 01 subtract, 10 use funct field
//   illegal      out  one-cycle pulse on an unsupported opcode in DECODE
//   state[3:0]   out  current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    state_t     cur;
    state_t     nxt;
    logic [1:0] aluop;

    // State register. Reset wins over any in-flight sequence, so a
    // half-done lw/sw never reaches its write-back/commit state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    assign state  = cur;
    assign aluop1 = aluop[1];
    assign aluop0 = aluop[0];

    // Next-state and output decode. Everything is a function of cur except
    // the memready-gated fetch strobes and the DECODE illegal pulse.
    always_comb begin
        nxt         = S_FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        pcsource    = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        illegal     = 1'b0;

        case (cur)
            S_FETCH: begin
                memread  = 1'b1;
                alusrcb  = SRCB_FOUR;
                pcsource = PCSRC_ALU;
                aluop    = ALUOP_ADD;
                // IR and PC only load on the cycle the fetch completes, so
                // a stalled fetch never advances PC more than once.
                irwrite  = memready;
                pcwrite  = memready;
                nxt      = memready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Branch target is computed speculatively here.
                alusrcb = SRCB_IMMSH;
                aluop   = ALUOP_ADD;
                case (op)
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDIEX;
                    default: begin
                        nxt     = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
                nxt     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                nxt     = memready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                regdst   = 1'b0;
                nxt      = S_FETCH;
            end

            S_MEMWR: begin
                // Level-held; memory commits on the memready cycle.
                memwrite = 1'b1;
                iord     = 1'b1;
                nxt      = memready ? S_FETCH : S_MEMWR;
            end

            S_EXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_B;
                aluop   = ALUOP_FUNCT;
                nxt     = S_RWB;
            end

            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                memtoreg = 1'b0;
                nxt      = S_FETCH;
            end

            S_BEQ: begin
                alusrca     = 1'b1;
                alusrcb     = SRCB_B;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                nxt         = S_FETCH;
            end

            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                nxt      = S_FETCH;
            end

            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
                nxt     = S_ADDIWB;
            end

            S_ADDIWB: begin
                regwrite = 1'b1;
                regdst   = 1'b0;
                memtoreg = 1'b0;
                nxt      = S_FETCH;
            end

            // Codes 12..15 are unreachable; recover to FETCH if ever seen.
            default: nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       memready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic       aluop1, aluop0, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop1(aluop1), .aluop0(aluop0), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       aluop1, aluop0, illegal;
        logic [3:0] state;
    } out_t;

    // stb = {pcwrite, irwrite, regwrite, memwrite, illegal}
    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic [4:0] stb;
        logic [1:0] aop;
    } vec_t;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04;
    localparam logic [5:0] J = 6'h02, ADDI = 6'h08, BAD = 6'h3f;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    function automatic out_t actual();
        out_t a;
        a = '{pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
              regdst, regwrite, alusrca, alusrcb, pcsource, aluop1, aluop0,
              illegal, state};
        return a;
    endfunction

    // Expected outputs of a state, straight from the per-state control table.
    function automatic out_t exp_out(input int st, input logic [5:0] o, input logic mr);
        out_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            0: begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
            1: begin
                e.alusrcb = 2'b11;
                e.illegal = !(o == RT || o == LW || o == SW || o == BEQ || o == J || o == ADDI);
            end
            2: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            3: begin e.memread = 1; e.iord = 1; end
            4: begin e.regwrite = 1; e.memtoreg = 1; end
            5: begin e.memwrite = 1; e.iord = 1; end
            6: begin e.alusrca = 1; e.aluop1 = 1; end
            7: begin e.regwrite = 1; e.regdst = 1; end
            8: begin e.alusrca = 1; e.aluop0 = 1; e.pcwritecond = 1; e.pcsource = 2'b01; end
            9: begin e.pcwrite = 1; e.pcsource = 2'b10; end
            10: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            11: begin e.regwrite = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic r, input logic [5:0] o, input logic mr,
                       input logic [3:0] st, input logic [4:0] stb, input logic [1:0] aop);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.mr = mr; v.st = st; v.stb = stb; v.aop = aop;
        vecs.push_back(v);
    endtask

    // Reference model: instruction-level plan of post-decode states.
    int mcur;
    int plan[$];

    task automatic model_step(input logic r, input logic [5:0] o, input logic mr);
        if (r) begin
            mcur = 0;
            plan.delete();
        end else if ((mcur == 0 || mcur == 3 || mcur == 5) && !mr) begin
            // memory wait: hold
        end else if (mcur == 0) begin
            mcur = 1;
        end else begin
            if (mcur == 1) begin
                plan.delete();
                case (o)
                    LW:   plan = '{2, 3, 4};
                    SW:   plan = '{2, 5};
                    RT:   plan = '{6, 7};
                    ADDI: plan = '{10, 11};
                    BEQ:  plan = '{8};
                    J:    plan = '{9};
                    default: ;
                endcase
            end
            mcur = (plan.size() != 0) ? plan.pop_front() : 0;
        end
    endtask

    initial begin
        logic [5:0] legal[6];
        out_t a;
        legal = '{RT, LW, SW, BEQ, J, ADDI};

        // name        rst op    mr st  stb       aop
        add("rst_out",  1, LW,   1, 0, 5'b11000, 2'b00);
        add("lw_f",     0, LW,   1, 0, 5'b11000, 2'b00);
        add("lw_d",     0, LW,   1, 1, 5'b00000, 2'b00);
        add("lw_ma",    0, LW,   1, 2, 5'b00000, 2'b00);
        add("lw_rd",    0, LW,   1, 3, 5'b00000, 2'b00);
        add("lw_wb",    0, LW,   1, 4, 5'b00100, 2'b00);
        add("rt_f",     0, RT,   1, 0, 5'b11000, 2'b00);
        add("rt_d",     0, RT,   1, 1, 5'b00000, 2'b00);
        add("rt_ex",    0, BAD,  1, 6, 5'b00000, 2'b10);
        add("rt_wb",    0, BAD,  1, 7, 5'b00100, 2'b00);
        add("beq_f",    0, BEQ,  1, 0, 5'b11000, 2'b00);
        add("beq_d",    0, BEQ,  1, 1, 5'b00000, 2'b00);
        add("beq_ex",   0, BEQ,  1, 8, 5'b00000, 2'b01);
        add("sw_f",     0, SW,   1, 0, 5'b11000, 2'b00);
        add("sw_d",     0, SW,   1, 1, 5'b00000, 2'b00);
        add("sw_ma",    0, SW,   1, 2, 5'b00000, 2'b00);
        add("sw_w0",    0, LW,   0, 5, 5'b00010, 2'b00);
        add("sw_w1",    0, BAD,  0, 5, 5'b00010, 2'b00);
        add("sw_w2",    0, RT,   0, 5, 5'b00010, 2'b00);
        add("sw_wr",    0, SW,   1, 5, 5'b00010, 2'b00);
        add("fw_0",     0, J,    0, 0, 5'b00000, 2'b00);
        add("fw_1",     0, J,    0, 0, 5'b00000, 2'b00);
        add("fw_2",     0, J,    1, 0, 5'b11000, 2'b00);
        add("j_d",      0, J,    1, 1, 5'b00000, 2'b00);
        add("j_ex",     0, J,    1, 9, 5'b10000, 2'b00);
        add("ill_f",    0, BAD,  1, 0, 5'b11000, 2'b00);
        add("ill_d",    0, BAD,  1, 1, 5'b00001, 2'b00);
        add("ill_f2",   0, LW,   1, 0, 5'b11000, 2'b00);
        add("ab_d",     0, LW,   1, 1, 5'b00000, 2'b00);
        add("ab_ma",    0, LW,   1, 2, 5'b00000, 2'b00);
        add("ab_rd",    1, LW,   0, 3, 5'b00000, 2'b00);
        add("ad_f",     0, ADDI, 1, 0, 5'b11000, 2'b00);
        add("ad_d",     0, ADDI, 1, 1, 5'b00000, 2'b00);
        add("ad_ex",    0, ADDI, 1, 10, 5'b00000, 2'b00);
        add("ad_wb",    0, ADDI, 1, 11, 5'b00100, 2'b00);
        add("ad_end",   0, RT,   1, 0, 5'b11000, 2'b00);

        reset = 1'b1; op = LW; memready = 1'b1;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; memready = vecs[i].mr;
            #1;
            a = actual();
            check({vecs[i].name, "/state"}, 32'(a.state), 32'(vecs[i].st));
            check({vecs[i].name, "/strobes"},
                  32'({a.pcwrite, a.irwrite, a.regwrite, a.memwrite, a.illegal}),
                  32'(vecs[i].stb));
            check({vecs[i].name, "/aluop"}, 32'({a.aluop1, a.aluop0}), 32'(vecs[i].aop));
            check({vecs[i].name, "/all"}, 32'(a),
                  32'(exp_out(int'(vecs[i].st), vecs[i].op, vecs[i].mr)));
            @(posedge clk);
        end

        // Random phase: resync with a reset, then let the model predict.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        mcur = 0;
        plan.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) < 2);
            // op must stay put between DECODE and MEMADR for lw/sw
            if (mcur != 2)
                op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 5)] : 6'($urandom);
            memready = ($urandom_range(0, 3) != 0);
            #1;
            check("rand", 32'(actual()), 32'(exp_out(mcur, op, memready)));
            if (aluop1 && aluop0) check("aluop_both", 32'({aluop1, aluop0}), 32'(2'b10));
            @(posedge clk);
            model_step(reset, op, memready);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath: a Moore-style state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives all datapath enables and multiplexer selects, and generates the `aluop1`/`aluop0` pair consumed by the ALU control decoder. It waits on a memory-ready handshake during every memory access.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction opcode `IR[31:26]`, valid from DECODE onward.
- `memready` in 1: memory access completes in the current cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite` out 1 each: standard multicycle datapath controls.
- `memtoreg`, `regdst`, `regwrite`, `alusrca` out 1 each: standard multicycle datapath controls.
- `alusrcb` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `pcsource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop1`, `aluop0` out 1 each: 00 = add, 01 = subtract, 10 = use funct field.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `state` out 4: current state encoding, for debug.

## Operation

State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unused and go to FETCH on the next edge.

Outputs not listed for a state are 0.

- **FETCH:** `memread`=1, `alusrcb`=01, aluop=00, `pcsource`=00.
  - `irwrite`=`memready`; `pcwrite`=`memready`.
  - Stays in FETCH while `memready`=0; otherwise goes to DECODE.
- **DECODE:** `alusrcb`=11, aluop=00. Next state by `op`:
  - 000000 (R-type) → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BEQ
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH, with `illegal`=1 in this cycle.
- **MEMADR:** `alusrca`=1, `alusrcb`=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD:** `memread`=1, `iord`=1. Holds while `memready`=0; then goes to MEMWB.
- **MEMWB:** `regwrite`=1, `memtoreg`=1, `regdst`=0. Goes to FETCH.
- **MEMWR:** `memwrite`=1, `iord`=1. Holds while `memready`=0; then goes to FETCH.
- **EXEC:** `alusrca`=1, `alusrcb`=00, aluop=10. Goes to RWB.
- **RWB:** `regwrite`=1, `regdst`=1, `memtoreg`=0. Goes to FETCH.
- **BEQ:** `alusrca`=1, `alusrcb`=00, aluop=01, `pcwritecond`=1, `pcsource`=01. Goes to FETCH.
- **JUMP:** `pcwrite`=1, `pcsource`=10. Goes to FETCH.
- **ADDIEX:** `alusrca`=1, `alusrcb`=10, aluop=00. Goes to ADDIWB.
- **ADDIWB:** `regwrite`=1, `regdst`=0, `memtoreg`=0. Goes to FETCH.

Output rules:
- Outputs are decoded combinationally from the `state` register.
- The only input-dependent outputs are `irwrite`/`pcwrite` (gated by `memready`) in FETCH and `illegal` in DECODE.
- `aluop1` and `aluop0` are never both 1.

## Timing
- **Reset:** `reset`=1 at a rising edge sets `state` to FETCH, whether or not an instruction is mid-sequence; no write strobe from the aborted state persists past that edge.
- **Outputs during/after reset:** FETCH values — `memread`=1, `alusrcb`=01, `pcsource`=00, aluop=00, `irwrite`=`pcwrite`=`memready`, all other outputs 0.
- **`op` sampling:** `op` is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- **Cycle counts with `memready` held at 1:**
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- **Wait states:** each cycle with `memready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During a wait, all outputs of that state stay stable except the `memready`-gated strobes.
- **Single-shot strobes:** `pcwrite`, `irwrite`, `regwrite` and `memwrite` assert in at most one cycle per instruction when `memready`=1. `memwrite` is level-held through wait cycles; memory commits the write on the `memready` cycle.

## Test plan
- Reset, then `op`=100011, `memready`=1 → state sequence 0,1,2,3,4,0. `regwrite`=`memtoreg`=1 only in state 4. `pcwrite`=1 only in cycle 0.
- R-type (`op`=000000) → states 0,1,6,7,0; `aluop1`=1, `aluop0`=0 in state 6. beq (`op`=000100) → 0,1,8,0 with aluop=01 and `pcwritecond`=1 in state 8.
- sw with `memready`=0 for 3 cycles in MEMWR → state 5 held 4 cycles, `memwrite`=1 throughout; exactly one `memready`=1 cycle, then FETCH.
- `memready`=0 in FETCH for 2 cycles → `irwrite`=`pcwrite`=0 during the wait, 1 in the third cycle, DECODE next.
- `op`=111111 in DECODE → `illegal`=1 for one cycle, FETCH next, no `regwrite`/`memwrite`. j (`op`=000010) → `pcsource`=10, `pcwrite`=1 in state 9.
- Assert `reset` while in MEMRD (state 3) → state 0 on the next edge, `regwrite` never asserted for that lw. Then addi → 0,1,10,11,0.
